// File: rtl/cdc_toggle_tx.sv
// Toggle-handshake CDC transmitter: launches data with a request toggle and waits for the synchronized ack toggle.
// Optional 2-entry skid FIFO ahead of launch when CDC_TOGGLE_TX_SKID_EN is defined.
module cdc_toggle_tx #(
    parameter int unsigned width       = 8,
    parameter int unsigned sync_stages = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in1_vld,
    output logic             in1_rdy,
    input  logic [width-1:0] in1_dat,
    output logic             xfer_toggle,
    output logic [width-1:0] xfer_dat,
    input  logic             ack_toggle,
    output logic             err
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic                   xfer_toggle_q, xfer_toggle_d;
    logic [width-1:0]       xfer_dat_q, xfer_dat_d;
    logic                   err_q, err_d;
    logic [sync_stages-1:0] ack_sync_q, ack_sync_d;
    logic                   ack_sync;
    logic                   launch_c;
    logic [width-1:0]       launch_dat_c;

    // ack_toggle arrives from another clock domain; only the last stage is used.
    assign ack_sync_d = {ack_sync_q[sync_stages-2:0], ack_toggle};
    assign ack_sync   = ack_sync_q[sync_stages-1];

`ifdef CDC_TOGGLE_TX_SKID_EN
    logic [width-1:0] fifo_q [2];
    logic [width-1:0] fifo_d [2];
    logic             rd_ptr_q, rd_ptr_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             accept_c;

    assign in1_rdy      = (count_q != 2'd2) && !rst;
    assign accept_c     = in1_vld && in1_rdy;
    assign launch_c     = (state_q == IDLE) && (count_q != 2'd0);
    assign launch_dat_c = fifo_q[rd_ptr_q];

    // FIFO bookkeeping; simultaneous push and pop leave the count unchanged.
    always_comb begin
        fifo_d   = fifo_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (accept_c) begin
            fifo_d[wr_ptr_q] = in1_dat;
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (launch_c) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({accept_c, launch_c})
            2'b10:   count_d = 2'(count_q + 2'd1);
            2'b01:   count_d = 2'(count_q - 2'd1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
            rd_ptr_q  <= 1'b0;
            wr_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
        end else begin
            fifo_q    <= fifo_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
        end
    end
`else
    assign in1_rdy      = (state_q == IDLE) && !rst;
    assign launch_c     = in1_vld && in1_rdy;
    assign launch_dat_c = in1_dat;
`endif

    // Next-state: launch from IDLE, hold bus in WAIT until the ack toggle matches.
    always_comb begin
        state_d       = state_q;
        xfer_toggle_d = xfer_toggle_q;
        xfer_dat_d    = xfer_dat_q;
        err_d         = err_q;
        case (state_q)
            IDLE: begin
                // A spurious ack edge while idle is a far-end protocol violation; the flag is sticky.
                if (ack_sync != xfer_toggle_q) begin
                    err_d = 1'b1;
                end
                if (launch_c) begin
                    xfer_dat_d    = launch_dat_c;
                    xfer_toggle_d = ~xfer_toggle_q;
                    state_d       = WAIT;
                end
            end
            WAIT: begin
                if (ack_sync == xfer_toggle_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            xfer_toggle_q <= 1'b0;
            xfer_dat_q    <= '0;
            err_q         <= 1'b0;
            ack_sync_q    <= '0;
        end else begin
            state_q       <= state_d;
            xfer_toggle_q <= xfer_toggle_d;
            xfer_dat_q    <= xfer_dat_d;
            err_q         <= err_d;
            ack_sync_q    <= ack_sync_d;
        end
    end

    assign xfer_toggle = xfer_toggle_q;
    assign xfer_dat    = xfer_dat_q;
    assign err         = err_q;

endmodule

// File: tb/tb_cdc_toggle_tx.sv
// Directed self-checking bench for cdc_toggle_tx with a behavioural far end that captures and acks after a programmable delay.
module tb_cdc_toggle_tx;

    localparam int unsigned W    = 8;
    localparam int unsigned SYNC = 2;

    logic         clk;
    logic         rst;
    logic         in1_vld;
    logic         in1_rdy;
    logic [W-1:0] in1_dat;
    logic         xfer_toggle;
    logic [W-1:0] xfer_dat;
    logic         ack_toggle;
    logic         err;

    int           n_checks = 0;
    int           n_pass   = 0;

    logic         far_en   = 1'b0;
    logic         far_tog  = 1'b0;
    logic         far_busy = 1'b0;
    int           far_dly  = 1;
    logic [W-1:0] cap_q[$];

    cdc_toggle_tx #(.width(W), .sync_stages(SYNC)) dut (
        .clk         (clk),
        .rst         (rst),
        .in1_vld     (in1_vld),
        .in1_rdy     (in1_rdy),
        .in1_dat     (in1_dat),
        .xfer_toggle (xfer_toggle),
        .xfer_dat    (xfer_dat),
        .ack_toggle  (ack_toggle),
        .err         (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Far end: capture on each new toggle, hold-check the bus, then echo the toggle after far_dly cycles.
    initial begin
        forever begin
            tick();
            if (far_en && (xfer_toggle !== far_tog)) begin
                int            dl;
                logic [W-1:0]  hold;
                dl       = far_dly;
                far_tog  = xfer_toggle;
                hold     = xfer_dat;
                far_busy = 1'b1;
                cap_q.push_back(xfer_dat);
                for (int i = 0; i < dl; i++) begin
                    tick();
                    check("hold_dat", 32'(xfer_dat), 32'(hold));
                    check("hold_tog", 32'(xfer_toggle), 32'(far_tog));
                end
                ack_toggle = far_tog;
                far_busy   = 1'b0;
            end
        end
    end

    task automatic do_reset();
        rst        = 1'b1;
        in1_vld    = 1'b0;
        ack_toggle = 1'b0;
        far_en     = 1'b0;
        far_tog    = 1'b0;
        cap_q.delete();
        tick();
        check("rst_rdy", 32'(in1_rdy), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        check("rst_tog", 32'(xfer_toggle), 32'd0);
        check("rst_dat", 32'(xfer_dat), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_rdy_after", 32'(in1_rdy), 32'd1);
    endtask

    task automatic send(input logic [W-1:0] d);
        int t = 0;
        while (!in1_rdy && t < 200) begin
            tick();
            t++;
        end
        check("send_rdy", 32'(in1_rdy), 32'd1);
        in1_vld = 1'b1;
        in1_dat = d;
        tick();
        in1_vld = 1'b0;
    endtask

    task automatic wait_done(input int n);
        int   t    = 0;
        logic done = 1'b0;
        while (!done && t < 300) begin
            tick();
            t++;
            done = (cap_q.size() >= n) && !far_busy;
        end
        check("wait_done", 32'(done), 32'd1);
        repeat (SYNC + 3) tick();
    endtask

    initial begin
        logic [W-1:0] exp3 [3];
        rst        = 1'b1;
        in1_vld    = 1'b0;
        in1_dat    = '0;
        ack_toggle = 1'b0;
        tick();

        // Single transfer with a one-cycle far-end ack delay.
        do_reset();
        far_en  = 1'b1;
        far_dly = 1;
        in1_vld = 1'b1;
        in1_dat = 8'h5A;
        tick();
        in1_vld = 1'b0;
`ifndef CDC_TOGGLE_TX_SKID_EN
        check("t1_dat", 32'(xfer_dat), 32'h5A);
        check("t1_tog", 32'(xfer_toggle), 32'd1);
        check("t1_rdy_e0", 32'(in1_rdy), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t1_rdy_wait", 32'(in1_rdy), 32'd0);
        end
        tick();
        check("t1_rdy_back", 32'(in1_rdy), 32'd1);
`else
        check("t1_tog_e0", 32'(xfer_toggle), 32'd0);
        check("t1_rdy_e0", 32'(in1_rdy), 32'd1);
        tick();
        check("t1_dat", 32'(xfer_dat), 32'h5A);
        check("t1_tog", 32'(xfer_toggle), 32'd1);
`endif
        wait_done(1);
        check("t1_cap_n", 32'(cap_q.size()), 32'd1);
        if (cap_q.size() >= 1) check("t1_cap", 32'(cap_q[0]), 32'h5A);
        check("t1_err", 32'(err), 32'd0);

        // Three back-to-back transfers with random ack delays.
        cap_q.delete();
        exp3[0] = 8'h01;
        exp3[1] = 8'h02;
        exp3[2] = 8'h03;
        for (int i = 0; i < 3; i++) begin
            far_dly = int'($urandom_range(0, 7));
            send(exp3[i]);
        end
        wait_done(3);
        check("t2_cap_n", 32'(cap_q.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            if (cap_q.size() > i) check("t2_cap", 32'(cap_q[i]), 32'(exp3[i]));
        end
        check("t2_tog", 32'(xfer_toggle), 32'd0);
        check("t2_err", 32'(err), 32'd0);

        // Spurious ack while idle: err after SYNC+1 edges, sticky until reset.
        do_reset();
        ack_toggle = 1'b1;
        for (int i = 0; i < SYNC; i++) begin
            tick();
            check("t3_err_early", 32'(err), 32'd0);
        end
        tick();
        check("t3_err_set", 32'(err), 32'd1);
        check("t3_idle", 32'(in1_rdy), 32'd1);
        check("t3_tog", 32'(xfer_toggle), 32'd0);
        repeat (5) tick();
        ack_toggle = 1'b0;
        repeat (5) tick();
        check("t3_err_sticky", 32'(err), 32'd1);
        do_reset();

        // One-cycle reset during WAIT abandons the transfer, then 0xA5 completes.
        send(8'h77);
        repeat (3) tick();
`ifndef CDC_TOGGLE_TX_SKID_EN
        check("t4_wait_rdy", 32'(in1_rdy), 32'd0);
`endif
        check("t4_wait_tog", 32'(xfer_toggle), 32'd1);
        rst = 1'b1;
        tick();
        check("t4_rst_tog", 32'(xfer_toggle), 32'd0);
        check("t4_rst_dat", 32'(xfer_dat), 32'd0);
        check("t4_rst_err", 32'(err), 32'd0);
        check("t4_rst_rdy", 32'(in1_rdy), 32'd0);
        rst = 1'b0;
        #1;
        check("t4_rdy", 32'(in1_rdy), 32'd1);
        repeat (3) tick();
        check("t4_no_launch", 32'(xfer_toggle), 32'd0);
        cap_q.delete();
        far_tog = 1'b0;
        far_en  = 1'b1;
        far_dly = 2;
        send(8'hA5);
        wait_done(1);
        check("t4_cap_n", 32'(cap_q.size()), 32'd1);
        if (cap_q.size() >= 1) check("t4_cap", 32'(cap_q[0]), 32'hA5);
        check("t4_tog", 32'(xfer_toggle), 32'd1);
        check("t4_err", 32'(err), 32'd0);
        check("t4_rdy_end", 32'(in1_rdy), 32'd1);

`ifdef CDC_TOGGLE_TX_SKID_EN
        // Long ack hold: one launched plus two buffered, fourth offer refused.
        do_reset();
        far_en  = 1'b1;
        far_dly = 20;
        in1_vld = 1'b1;
        in1_dat = 8'h11;
        tick();
        check("t5_rdy1", 32'(in1_rdy), 32'd1);
        in1_dat = 8'h22;
        tick();
        check("t5_launch", 32'(xfer_dat), 32'h11);
        check("t5_rdy2", 32'(in1_rdy), 32'd1);
        in1_dat = 8'h33;
        tick();
        check("t5_full", 32'(in1_rdy), 32'd0);
        in1_dat = 8'h44;
        tick();
        check("t5_full2", 32'(in1_rdy), 32'd0);
        in1_vld = 1'b0;
        wait_done(3);
        check("t5_cap_n", 32'(cap_q.size()), 32'd3);
        if (cap_q.size() >= 3) begin
            check("t5_cap0", 32'(cap_q[0]), 32'h11);
            check("t5_cap1", 32'(cap_q[1]), 32'h22);
            check("t5_cap2", 32'(cap_q[2]), 32'h33);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
